// File: rtl/vga_scan.sv
// VGA 640x480 scan generator: divides clk into a pixel enable, walks the raw
// col/row counters, and registers sync and blanked colour one pixel behind them.
module vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pix_rgb,
    output logic [9:0]  col,
    output logic [9:0]  row,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_tick
);

    localparam int CLK_DIV = 4;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [1:0] div;
    logic       pix_en;
    logic       active;
    logic       line_end;
    logic       frame_end;

    assign pix_en    = (div == DIV_LAST);
    assign active    = (col < H_VIS) && (row < V_VIS);
    assign line_end  = (col == H_LAST);
    assign frame_end = line_end && (row == V_LAST);

    // Decoded straight from registers and the divider, so it is a clean
    // single-cycle pulse that is forced low while div is held at 0 in reset.
    assign frame_tick = pix_en && frame_end;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (pix_en) begin
            if (line_end) begin
                col <= 10'd0;
                row <= frame_end ? 10'd0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // Sync and colour are decoded from the pre-increment counters, which puts
    // all three exactly one pixel period behind col/row and aligned together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs        <= 1'b1;
            vs        <= 1'b1;
            {r, g, b} <= 12'h000;
        end else if (pix_en) begin
            hs        <= !((col >= HS_FIRST) && (col <= HS_LAST));
            vs        <= !((row >= VS_FIRST) && (row <= VS_LAST));
            {r, g, b} <= active ? pix_rgb : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan: full-size timing on one instance, and frame-level
// behaviour on a second instance with shrunken porches so whole frames fit the run.
module tb_vga_scan;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int S_HT = 25, S_VT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Full-size instance
    logic        rst_n = 1'b0;
    int          pix_mode = 0;
    logic [11:0] pix_rgb;
    logic [9:0]  col, row;
    logic        hs, vs, frame_tick;
    logic [3:0]  r, g, b;

    assign pix_rgb = (pix_mode == 2) ? 12'hFFF :
                     ((pix_mode == 1) && (col == 10'd5) && (row == 10'd7)) ? 12'hF0F : 12'h000;

    vga_scan dut (
        .clk(clk), .rst_n(rst_n), .pix_rgb(pix_rgb), .col(col), .row(row),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .frame_tick(frame_tick)
    );

    // Shrunken instance
    logic        s_rst_n = 1'b0;
    logic [11:0] s_pix;
    logic [9:0]  s_col, s_row;
    logic        s_hs, s_vs, s_frame_tick;
    logic [3:0]  s_r, s_g, s_b;

    assign s_pix = 12'hFFF;

    vga_scan #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) sdut (
        .clk(clk), .rst_n(s_rst_n), .pix_rgb(s_pix), .col(s_col), .row(s_row),
        .hs(s_hs), .vs(s_vs), .r(s_r), .g(s_g), .b(s_b), .frame_tick(s_frame_tick)
    );

    task automatic wait_pos(input int c, input int rr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((int'(col) == c) && ((rr < 0) || (int'(row) == rr))) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int t0;
        pix_mode = 2;
        rst_n    = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (col !== 10'd0 || row !== 10'd0) begin
            errors++; $display("FAIL reset_counters: col=%0d row=%0d, want 0 0", col, row);
        end
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1) begin
            errors++; $display("FAIL reset_sync: hs=%b vs=%b, want 1 1", hs, vs);
        end
        checks++;
        if ({r, g, b} !== 12'h000 || frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_rgb_tick: rgb=%h tick=%b, want 000 0", {r, g, b}, frame_tick);
        end
        rst_n = 1'b1;
        t0    = cyc;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 10'd0) begin
            errors++; $display("FAIL release_edge3: col=%0d after %0d edges, want 0", col, cyc - t0);
        end
        @(negedge clk);
        checks++;
        if (col !== 10'd1 || row !== 10'd0) begin
            errors++; $display("FAIL release_edge4: col=%0d row=%0d after %0d edges, want 1 0", col, row, cyc - t0);
        end
    endtask

    task automatic test_line();
        int  t0, t1, t2, ta, tb, row_a;
        bit  ok;
        pix_mode = 0;
        wait_pos(656, -1, 4000, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL line_wait656: col=%0d, want 656", col); end
        t1 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hs === 1'b0) begin t1 = cyc; break; end
        end
        checks++;
        if (t1 - t0 != 4) begin
            errors++; $display("FAIL hs_fall_delay: %0d clk after col=656, want 4", t1 - t0);
        end
        t2 = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (hs === 1'b1) begin t2 = cyc; break; end
        end
        checks++;
        if (t2 - t1 != 384) begin
            errors++; $display("FAIL hs_low_width: %0d clk, want 384", t2 - t1);
        end
        wait_pos(0, -1, 4000, ok);
        ta    = cyc;
        row_a = int'(row);
        wait_pos(1, -1, 100, ok);
        wait_pos(0, -1, 4000, ok);
        tb = cyc;
        checks++;
        if (tb - ta != 3200) begin
            errors++; $display("FAIL line_period: %0d clk, want 3200", tb - ta);
        end
        checks++;
        if (int'(row) != row_a + 1 || vs !== 1'b1) begin
            errors++; $display("FAIL row_step: row=%0d vs=%b, want %0d 1", row, vs, row_a + 1);
        end
    endtask

    task automatic test_pixel();
        int t0, t1, n, early;
        bit ok;
        pix_mode = 1;
        early    = 0;
        ok       = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if ({r, g, b} !== 12'h000) early++;
            if (col == 10'd5 && row == 10'd7) begin ok = 1'b1; break; end
        end
        t0 = cyc;
        checks++;
        if (!ok || early != 0) begin
            errors++; $display("FAIL pixel_approach: reached=%b nonzero_samples=%0d, want 1 0", ok, early);
        end
        t1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({r, g, b} !== 12'h000) begin t1 = cyc; break; end
        end
        checks++;
        if (t1 - t0 != 4 || {r, g, b} !== 12'hF0F) begin
            errors++; $display("FAIL pixel_onset: delay=%0d rgb=%h, want 4 F0F", t1 - t0, {r, g, b});
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if ({r, g, b} !== 12'hF0F) break;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4 || {r, g, b} !== 12'h000) begin
            errors++; $display("FAIL pixel_width: %0d clk then rgb=%h, want 4 then 000", n, {r, g, b});
        end
    endtask

    task automatic test_fill();
        int  pc, pr, bad, fff;
        bit  ok;
        logic [11:0] exp_rgb;
        logic        exp_hs;
        pix_mode = 2;
        wait_pos(0, 8, 10000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fill_wait: col=%0d row=%0d, want 0 8", col, row); end
        bad = 0;
        fff = 0;
        for (int i = 0; i < 3200; i++) begin
            pc      = (col == 10'd0) ? 799 : int'(col) - 1;
            pr      = (col == 10'd0) ? int'(row) - 1 : int'(row);
            exp_rgb = (pc < 640 && pr < 480) ? 12'hFFF : 12'h000;
            exp_hs  = !(pc >= 656 && pc <= 751);
            if ({r, g, b} === 12'hFFF) fff++;
            if ({r, g, b} !== exp_rgb || hs !== exp_hs || vs !== 1'b1) begin
                if (bad == 0)
                    $display("FAIL fill_sample: col=%0d rgb=%h hs=%b vs=%b, want %h %b 1",
                             col, {r, g, b}, hs, vs, exp_rgb, exp_hs);
                bad++;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_line: %0d bad samples, want 0", bad); end
        checks++;
        if (fff != 2560) begin errors++; $display("FAIL fill_count: %0d FFF clk, want 2560", fff); end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        pix_mode = 2;
        wait_pos(300, 9, 5000, ok);
        checks++;
        if (!ok || {r, g, b} !== 12'hFFF) begin
            errors++; $display("FAIL mid_pre: reached=%b rgb=%h, want 1 FFF", ok, {r, g, b});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (col !== 10'd0 || row !== 10'd0 || {r, g, b} !== 12'h000 || hs !== 1'b1 || vs !== 1'b1
            || frame_tick !== 1'b0) begin
            errors++; $display("FAIL mid_async: col=%0d row=%0d rgb=%h hs=%b vs=%b tick=%b, want 0 0 000 1 1 0",
                               col, row, {r, g, b}, hs, vs, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0    = cyc;
        repeat (3) @(negedge clk);
        checks++;
        if (col !== 10'd0 || row !== 10'd0) begin
            errors++; $display("FAIL mid_edge3: col=%0d row=%0d, want 0 0", col, row);
        end
        @(negedge clk);
        checks++;
        if (col !== 10'd1 || row !== 10'd0) begin
            errors++; $display("FAIL mid_edge4: col=%0d row=%0d after %0d edges, want 1 0", col, row, cyc - t0);
        end
    endtask

    task automatic test_frame();
        int tr, tk, pc, pr, bad, ticks, idx1, idx2, vs_low, fff, range_bad;
        logic [11:0] exp_rgb;
        logic        exp_hs, exp_vs;
        @(negedge clk);
        s_rst_n = 1'b1;
        tr      = cyc;
        tk      = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_frame_tick === 1'b1) begin tk = cyc; break; end
        end
        checks++;
        if (tk - tr != 1099) begin
            errors++; $display("FAIL first_tick: %0d clk after release, want 1099", tk - tr);
        end
        bad = 0; ticks = 0; idx1 = -1; idx2 = -1; vs_low = 0; fff = 0; range_bad = 0;
        for (int i = 1; i <= 2200; i++) begin
            @(negedge clk);
            pc      = (s_col == 10'd0) ? S_HT - 1 : int'(s_col) - 1;
            pr      = (s_col == 10'd0) ? ((s_row == 10'd0) ? S_VT - 1 : int'(s_row) - 1) : int'(s_row);
            exp_rgb = (pc < S_HA && pr < S_VA) ? 12'hFFF : 12'h000;
            exp_hs  = !(pc >= 18 && pc <= 21);
            exp_vs  = !(pr >= 7 && pr <= 8);
            if (s_frame_tick === 1'b1) begin
                ticks++;
                if (idx1 < 0) idx1 = i; else idx2 = i;
            end
            if (s_vs === 1'b0) vs_low++;
            if ({s_r, s_g, s_b} === 12'hFFF) fff++;
            if (s_col > 10'd24 || s_row > 10'd10) range_bad++;
            if ({s_r, s_g, s_b} !== exp_rgb || s_hs !== exp_hs || s_vs !== exp_vs) begin
                if (bad == 0)
                    $display("FAIL frame_sample: col=%0d row=%0d rgb=%h hs=%b vs=%b, want %h %b %b",
                             s_col, s_row, {s_r, s_g, s_b}, s_hs, s_vs, exp_rgb, exp_hs, exp_vs);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL frame_model: %0d bad samples, want 0", bad); end
        checks++;
        if (ticks != 2 || idx1 != 1100 || idx2 != 2200) begin
            errors++; $display("FAIL tick_period: count=%0d at %0d,%0d, want 2 at 1100,2200", ticks, idx1, idx2);
        end
        checks++;
        if (vs_low != 400) begin errors++; $display("FAIL vs_low: %0d clk over 2 frames, want 400", vs_low); end
        checks++;
        if (fff != 768) begin errors++; $display("FAIL frame_fill: %0d FFF clk, want 768", fff); end
        checks++;
        if (range_bad != 0) begin errors++; $display("FAIL counter_range: %0d samples, want 0", range_bad); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pixel();
        test_fill();
        test_reset_mid();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
